ifetch_mem_responder: RTL and testbench

- Responder end of the instruction-fetch interface: accepts a fetch request (address plus valid/ready), reads one 32-bit word from an internal instruction store, and returns it on a valid/ready response channel after a programmable latency.
- Sits between the fetch unit and its instruction source in the NPC core. Replaces the combinational mem_data path with a latency-bearing, handshaked memory model.
- A side load port preloads or patches the store.

---
 rtl/ifetch_mem_responder_if.sv | 21 ++
 rtl/ifetch_mem_responder.sv | 109 ++++++++++
 tb/tb_ifetch_mem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_mem_responder_if.sv
// Instruction-fetch request/response channel between a fetch unit (master) and
// its instruction source (slave).
interface ifetch_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/ifetch_mem_responder.sv
// Handshaked instruction store: one outstanding fetch, word latched at accept,
// response presented LATENCY+1 cycles later and held until taken.
module ifetch_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  ifetch_mem_responder_if.slave       bus,
  input  logic                        load_en,
  input  logic [31:0]                 load_addr,
  input  logic [31:0]                 load_data
);

  if (LATENCY > 15) begin : gen_latency_check
    $error("ifetch_mem_responder: LATENCY must be in 0..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("ifetch_mem_responder: DEPTH must be a power of two >= 2");
  end

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [32:0] StoreBytes = 33'(DEPTH) << 2;
  localparam logic [3:0]  LatCnt     = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    data_q;
  logic           err_q;
  logic           accept;

  logic [31:0]    mem [DEPTH];

  // Shared decode for fetches and loads: offset wraps, so addresses below BASE land
  // far out of range.
  logic [31:0]    req_off, load_off;
  logic           req_err, load_err;
  logic [AW-1:0]  req_idx, load_idx;

  assign req_off  = bus.req_addr - BASE;
  assign load_off = load_addr - BASE;
  assign req_err  = (bus.req_addr[1:0] != 2'b00) || ({1'b0, req_off} >= StoreBytes);
  assign load_err = (load_addr[1:0] != 2'b00) || ({1'b0, load_off} >= StoreBytes);
  assign req_idx  = req_off[AW+1:2];
  assign load_idx = load_off[AW+1:2];

  assign accept = (state_q == StIdle) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q <= req_err ? 32'd0 : mem[req_idx];
        err_q  <= req_err;
      end
    end
  end

  // Store is never cleared; the read above samples the pre-write word on a same-edge load.
  always_ff @(posedge clk) begin
    if (load_en && !load_err) begin
      mem[load_idx] <= load_data;
    end
  end

  // WAIT spends cnt+1 cycles, so resp_valid rises LATENCY+1 edges after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StWait;
          cnt_d   = LatCnt;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle) && !rst;
    bus.resp_valid = (state_q == StResp);
    bus.resp_data  = data_q;
    bus.resp_err   = err_q;
  end

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Drives one stimulus stream into a LATENCY=2 and a LATENCY=0 responder and checks
// both against a cycle-count model of the fetch protocol.
module tb_ifetch_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_ready;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL %s: no completion within cycle bound", what);
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a - BASE) >= 32'(4 * DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned LAT = (g == 0) ? 2 : 0;

    ifetch_mem_responder_if bus ();
    assign bus.req_valid  = req_valid;
    assign bus.req_addr   = req_addr;
    assign bus.resp_ready = resp_ready;

    ifetch_mem_responder #(
      .DEPTH   (DEPTH),
      .BASE    (BASE),
      .LATENCY (LAT)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data)
    );

    // Model: a fetch accepted at edge A is visible from edge A+1+LAT until taken.
    int          m_cyc = 0;
    int          m_acc = 0;
    logic        m_pend = 1'b0;
    logic        m_rst = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_mem [DEPTH];
    logic        exp_valid;

    assign exp_valid = m_pend && ((m_cyc - m_acc) >= 1 + int'(LAT));

    always @(posedge clk) begin
      m_cyc <= m_cyc + 1;
      m_rst <= rst;
      if (rst) begin
        m_pend <= 1'b0;
      end else if (m_pend) begin
        if (exp_valid && resp_ready) m_pend <= 1'b0;
      end else if (req_valid) begin
        m_pend <= 1'b1;
        m_acc  <= m_cyc + 1;
        m_err  <= bad_addr(req_addr);
        m_data <= bad_addr(req_addr) ? 32'd0 : m_mem[word_of(req_addr)];
      end
      if (load_en && !bad_addr(load_addr)) m_mem[word_of(load_addr)] <= load_data;
    end

    always @(negedge clk) begin
      if (m_cyc > 0) begin
        check($sformatf("L%0d req_ready @%0d", LAT, m_cyc), 32'(bus.req_ready),
              32'(!m_pend && !rst));
        check($sformatf("L%0d resp_valid @%0d", LAT, m_cyc), 32'(bus.resp_valid),
              32'(exp_valid));
        if (exp_valid) begin
          check($sformatf("L%0d resp_data @%0d", LAT, m_cyc), bus.resp_data, m_data);
          check($sformatf("L%0d resp_err @%0d", LAT, m_cyc), 32'(bus.resp_err), 32'(m_err));
        end
        if (m_rst) begin
          check($sformatf("L%0d reset resp_data @%0d", LAT, m_cyc), bus.resp_data, 32'd0);
          check($sformatf("L%0d reset resp_err @%0d", LAT, m_cyc), 32'(bus.resp_err), 32'd0);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    step(1);
    load_en = 1'b0;
  endtask

  // Issue one fetch with both responders idle; pin the L2 timing and the L0 data.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e,
                       input int stall);
    int n = 0;
    resp_ready = (stall == 0);
    req_valid  = 1'b1;
    req_addr   = a;
    while (!lane[0].bus.req_ready && n < 20) begin
      step(1);
      n++;
    end
    if (n == 20) timeout("fetch accept");
    step(1);
    req_valid = 1'b0;
    load_en   = 1'b0;
    req_addr  = ~a;
    step(1);
    check("L2 valid at accept+1", 32'(lane[0].bus.resp_valid), 32'd0);
    check("L0 valid at accept+1", 32'(lane[1].bus.resp_valid), 32'd1);
    check("L0 data at accept+1", lane[1].bus.resp_data, d);
    check("L0 err at accept+1", 32'(lane[1].bus.resp_err), 32'(e));
    step(1);
    check("L2 valid at accept+2", 32'(lane[0].bus.resp_valid), 32'd0);
    step(1);
    check("L2 valid at accept+3", 32'(lane[0].bus.resp_valid), 32'd1);
    check("L2 data at accept+3", lane[0].bus.resp_data, d);
    check("L2 err at accept+3", 32'(lane[0].bus.resp_err), 32'(e));
    for (int i = 0; i < stall; i++) begin
      step(1);
      check("L2 stall valid", 32'(lane[0].bus.resp_valid), 32'd1);
      check("L2 stall data", lane[0].bus.resp_data, d);
      check("L2 stall err", 32'(lane[0].bus.resp_err), 32'(e));
      check("L2 stall req_ready", 32'(lane[0].bus.req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step(1);
    check("L2 valid after handshake", 32'(lane[0].bus.resp_valid), 32'd0);
    check("L2 req_ready after handshake", 32'(lane[0].bus.req_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;

    step(1);
    check("reset req_ready", 32'(lane[0].bus.req_ready), 32'd0);
    check("reset resp_valid", 32'(lane[0].bus.resp_valid), 32'd0);
    check("reset resp_data", lane[0].bus.resp_data, 32'd0);
    check("reset resp_err", 32'(lane[0].bus.resp_err), 32'd0);
    step(1);
    rst = 1'b0;

    load(32'h8000_0000, 32'h0000_0413);
    load(32'h8000_0004, 32'h0010_0093);
    load(32'h8000_0008, 32'h1234_5678);
    load(32'h8000_1000, 32'hFFFF_FFFF);

    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0);
    fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 5);
    fetch(32'h8000_0002, 32'd0, 1'b1, 0);
    fetch(32'h8000_1000, 32'd0, 1'b1, 0);
    fetch(32'h7FFF_FFFC, 32'd0, 1'b1, 0);

    // Same-edge load and fetch of one word: fetch sees the old contents.
    load_en   = 1'b1;
    load_addr = 32'h8000_0008;
    load_data = 32'hDEAD_BEEF;
    fetch(32'h8000_0008, 32'h1234_5678, 1'b0, 0);
    fetch(32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 0);

    // Reset while the L2 responder is still waiting.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0000;
    step(1);
    req_valid = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    check("mid reset resp_valid", 32'(lane[0].bus.resp_valid), 32'd0);
    check("mid reset req_ready", 32'(lane[0].bus.req_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("no response after reset", 32'(lane[0].bus.resp_valid), 32'd0);
    end
    check("req_ready after reset", 32'(lane[0].bus.req_ready), 32'd1);
    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0);

    // Continuous requests: the L0 responder answers every third cycle.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0004;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (lane[1].bus.resp_valid) n++;
    end
    check("L0 responses in 12 cycles", 32'(n), 32'd4);
    req_valid = 1'b0;
    n = 0;
    while (!(lane[0].bus.req_ready && lane[1].bus.req_ready) && n < 20) begin
      step(1);
      n++;
    end
    if (n == 20) timeout("drain");
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
